access_ctrl_gen: RTL and testbench

ACCESS_CTRL_GEN -- requirements
Module: access_ctrl_gen

---
 rtl/access_ctrl_gen_pkg.sv | 32 +++
 rtl/access_ctrl_gen_if.sv | 22 ++
 rtl/access_ctrl_gen_cred_table.sv | 48 ++++
 rtl/access_ctrl_gen.sv | 232 +++++++++++++++++++++++
 tb/tb_access_ctrl_gen.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/access_ctrl_gen_pkg.sv
// Shared types and default credentials for the keypad access controller.
// Credentials are written as one hex nibble per digit and repacked to DIGIT_W bits per digit.
package access_pkg;

    typedef enum logic [2:0] {
        U_ENTRY  = 3'd0,
        U_SEARCH = 3'd1,
        P_ENTRY  = 3'd2,
        P_CHECK  = 3'd3,
        GRANTED  = 3'd4,
        LOCKED   = 3'd5
    } state_e;

    localparam logic [31:0] USER_A_NIB = 32'h0000_1111;
    localparam logic [31:0] PASS_A_NIB = 32'h0001_1111;
    localparam logic [31:0] USER_B_NIB = 32'h0000_2468;
    localparam logic [31:0] PASS_B_NIB = 32'h0001_3579;
    localparam int          USER_B_IDX = 5;

    // Digits wider than DIGIT_W are truncated, so narrow builds keep the same entry layout.
    function automatic logic [63:0] pack_digits(logic [31:0] nib, int n, int w);
        logic [63:0] r;
        logic [63:0] m;
        r = '0;
        m = (64'd1 << w) - 64'd1;
        for (int i = n - 1; i >= 0; i--) begin
            r = (r << w) | ((64'(nib) >> (4 * i)) & m);
        end
        return r;
    endfunction

endpackage

// File: rtl/access_ctrl_gen_if.sv
// Signal bundle for one access controller: keypad inputs plus status outputs.
// valid/ready: b_ac is a one-cycle strobe qualifying swt_ac; there is no ready, a strobe the FSM cannot use is dropped.
interface access_ctrl_gen_if #(
    parameter int DIGIT_W   = 4,
    parameter int NUM_USERS = 8,
    parameter int MAX_FAILS = 3
) ();
    logic                             b_ac;
    logic [DIGIT_W-1:0]               swt_ac;
    logic                             clr;
    logic                             logout;
    logic                             led_r;
    logic                             led_g;
    logic                             locked;
    logic [$clog2(NUM_USERS)-1:0]     user_idx;
    logic [$clog2(MAX_FAILS+1)-1:0]   fail_cnt;

    modport master (output b_ac, swt_ac, clr, logout,
                    input  led_r, led_g, locked, user_idx, fail_cnt);
    modport slave  (input  b_ac, swt_ac, clr, logout,
                    output led_r, led_g, locked, user_idx, fail_cnt);
endinterface

// File: rtl/access_ctrl_gen_cred_table.sv
// Credential ROM: registered read of {user, password}, data appears one cycle after the address.
// The second credential sits at index 5, or at the last index when the table is smaller.
module cred_table
    import access_pkg::*;
#(
    parameter int NUM_USERS   = 8,
    parameter int DIGIT_W     = 4,
    parameter int USER_DIGITS = 4,
    parameter int PASS_DIGITS = 5,
    localparam int AW = $clog2(NUM_USERS),
    localparam int UW = DIGIT_W * USER_DIGITS,
    localparam int PW = DIGIT_W * PASS_DIGITS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr_i,
    output logic [UW-1:0] user_o,
    output logic [PW-1:0] pass_o
);
    localparam int B_IDX = (NUM_USERS > USER_B_IDX) ? USER_B_IDX : NUM_USERS - 1;

    localparam logic [UW-1:0] USER_A = UW'(pack_digits(USER_A_NIB, USER_DIGITS, DIGIT_W));
    localparam logic [PW-1:0] PASS_A = PW'(pack_digits(PASS_A_NIB, PASS_DIGITS, DIGIT_W));
    localparam logic [UW-1:0] USER_B = UW'(pack_digits(USER_B_NIB, USER_DIGITS, DIGIT_W));
    localparam logic [PW-1:0] PASS_B = PW'(pack_digits(PASS_B_NIB, PASS_DIGITS, DIGIT_W));

    logic [UW-1:0] user_q;
    logic [PW-1:0] pass_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            user_q <= '0;
            pass_q <= '0;
        end else if (addr_i == AW'(0)) begin
            user_q <= USER_A;
            pass_q <= PASS_A;
        end else if (addr_i == AW'(B_IDX)) begin
            user_q <= USER_B;
            pass_q <= PASS_B;
        end else begin
            user_q <= '1;
            pass_q <= '1;
        end
    end

    assign user_o = user_q;
    assign pass_o = pass_q;
endmodule

// File: rtl/access_ctrl_gen.sv
// Keypad access controller: user ID entry, table search, password check, grant and timed lockout.
// A missing user still walks through password entry, so the outcome never reveals which part was wrong.
module access_ctrl_gen
    import access_pkg::*;
#(
    parameter int DIGIT_W     = 4,
    parameter int USER_DIGITS = 4,
    parameter int PASS_DIGITS = 5,
    parameter int NUM_USERS   = 8,
    parameter int MAX_FAILS   = 3,
    parameter int LOCK_CYCLES = 1000,
    localparam int AW = $clog2(NUM_USERS),
    localparam int FW = $clog2(MAX_FAILS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               b_ac,
    input  logic [DIGIT_W-1:0] swt_ac,
    input  logic               clr,
    input  logic               logout,
    output logic               led_r,
    output logic               led_g,
    output logic               locked,
    output logic [AW-1:0]      user_idx,
    output logic [FW-1:0]      fail_cnt
);
    localparam int UW = DIGIT_W * USER_DIGITS;
    localparam int PW = DIGIT_W * PASS_DIGITS;
    localparam int CW = $clog2(((USER_DIGITS > PASS_DIGITS) ? USER_DIGITS : PASS_DIGITS) + 1);
    localparam int LW = $clog2(LOCK_CYCLES + 1);

    state_e        state_q, state_d;
    logic [UW-1:0] ubuf_q, ubuf_d;
    logic [PW-1:0] pbuf_q, pbuf_d;
    logic [CW-1:0] dcnt_q, dcnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] daddr_q, daddr_d;
    logic          dvld_q, dvld_d;
    logic [AW-1:0] midx_q, midx_d;
    logic          mvld_q, mvld_d;
    logic          phase_q, phase_d;
    logic [FW-1:0] fail_q, fail_d;
    logic [LW-1:0] lcnt_q, lcnt_d;
    logic          led_g_q, led_g_d;
    logic          led_r_q;
    logic          locked_q, locked_d;
    logic [AW-1:0] uidx_q, uidx_d;
    logic [FW-1:0] fail_inc;
    logic [UW-1:0] tbl_user;
    logic [PW-1:0] tbl_pass;

    cred_table #(
        .NUM_USERS  (NUM_USERS),
        .DIGIT_W    (DIGIT_W),
        .USER_DIGITS(USER_DIGITS),
        .PASS_DIGITS(PASS_DIGITS)
    ) u_table (
        .clk   (clk),
        .rst   (rst),
        .addr_i(addr_q),
        .user_o(tbl_user),
        .pass_o(tbl_pass)
    );

    always_comb begin
        state_d  = state_q;
        ubuf_d   = ubuf_q;
        pbuf_d   = pbuf_q;
        dcnt_d   = dcnt_q;
        addr_d   = addr_q;
        daddr_d  = daddr_q;
        dvld_d   = dvld_q;
        midx_d   = midx_q;
        mvld_d   = mvld_q;
        phase_d  = phase_q;
        fail_d   = fail_q;
        lcnt_d   = lcnt_q;
        led_g_d  = led_g_q;
        locked_d = locked_q;
        uidx_d   = uidx_q;
        fail_inc = fail_q + FW'(1);

        unique case (state_q)
            U_ENTRY: begin
                if (clr) begin
                    ubuf_d = '0;
                    pbuf_d = '0;
                    dcnt_d = '0;
                    mvld_d = 1'b0;
                end else if (b_ac) begin
                    ubuf_d = UW'({ubuf_q, swt_ac});
                    if (dcnt_q == CW'(USER_DIGITS - 1)) begin
                        dcnt_d  = '0;
                        addr_d  = '0;
                        dvld_d  = 1'b0;
                        state_d = U_SEARCH;
                    end else begin
                        dcnt_d = dcnt_q + CW'(1);
                    end
                end
            end
            // addr_q leads the returned row by one cycle; daddr_q names the row being compared.
            U_SEARCH: begin
                dvld_d  = 1'b1;
                daddr_d = addr_q;
                if (addr_q != AW'(NUM_USERS - 1)) addr_d = addr_q + AW'(1);
                if (dvld_q && tbl_user == ubuf_q) begin
                    midx_d  = daddr_q;
                    mvld_d  = 1'b1;
                    state_d = P_ENTRY;
                end else if (dvld_q && daddr_q == AW'(NUM_USERS - 1)) begin
                    midx_d  = '0;
                    mvld_d  = 1'b0;
                    state_d = P_ENTRY;
                end
            end
            P_ENTRY: begin
                if (clr) begin
                    ubuf_d  = '0;
                    pbuf_d  = '0;
                    dcnt_d  = '0;
                    mvld_d  = 1'b0;
                    midx_d  = '0;
                    state_d = U_ENTRY;
                end else if (b_ac) begin
                    pbuf_d = PW'({pbuf_q, swt_ac});
                    if (dcnt_q == CW'(PASS_DIGITS - 1)) begin
                        dcnt_d  = '0;
                        addr_d  = midx_q;
                        phase_d = 1'b0;
                        state_d = P_CHECK;
                    end else begin
                        dcnt_d = dcnt_q + CW'(1);
                    end
                end
            end
            P_CHECK: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    ubuf_d  = '0;
                    pbuf_d  = '0;
                    addr_d  = '0;
                    if (mvld_q && tbl_pass == pbuf_q) begin
                        led_g_d = 1'b1;
                        uidx_d  = midx_q;
                        fail_d  = '0;
                        state_d = GRANTED;
                    end else begin
                        mvld_d = 1'b0;
                        midx_d = '0;
                        fail_d = fail_inc;
                        if (fail_inc == FW'(MAX_FAILS)) begin
                            locked_d = 1'b1;
                            lcnt_d   = LW'(LOCK_CYCLES - 1);
                            state_d  = LOCKED;
                        end else begin
                            state_d = U_ENTRY;
                        end
                    end
                end
            end
            GRANTED: begin
                if (logout) begin
                    led_g_d = 1'b0;
                    uidx_d  = '0;
                    mvld_d  = 1'b0;
                    midx_d  = '0;
                    ubuf_d  = '0;
                    pbuf_d  = '0;
                    addr_d  = '0;
                    state_d = U_ENTRY;
                end
            end
            LOCKED: begin
                if (lcnt_q == '0) begin
                    locked_d = 1'b0;
                    fail_d   = '0;
                    state_d  = U_ENTRY;
                end else begin
                    lcnt_d = lcnt_q - LW'(1);
                end
            end
            default: state_d = U_ENTRY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= U_ENTRY;
            ubuf_q   <= '0;
            pbuf_q   <= '0;
            dcnt_q   <= '0;
            addr_q   <= '0;
            daddr_q  <= '0;
            dvld_q   <= 1'b0;
            midx_q   <= '0;
            mvld_q   <= 1'b0;
            phase_q  <= 1'b0;
            fail_q   <= '0;
            lcnt_q   <= '0;
            led_g_q  <= 1'b0;
            led_r_q  <= 1'b1;
            locked_q <= 1'b0;
            uidx_q   <= '0;
        end else begin
            state_q  <= state_d;
            ubuf_q   <= ubuf_d;
            pbuf_q   <= pbuf_d;
            dcnt_q   <= dcnt_d;
            addr_q   <= addr_d;
            daddr_q  <= daddr_d;
            dvld_q   <= dvld_d;
            midx_q   <= midx_d;
            mvld_q   <= mvld_d;
            phase_q  <= phase_d;
            fail_q   <= fail_d;
            lcnt_q   <= lcnt_d;
            led_g_q  <= led_g_d;
            led_r_q  <= ~led_g_d;
            locked_q <= locked_d;
            uidx_q   <= uidx_d;
        end
    end

    assign led_r    = led_r_q;
    assign led_g    = led_g_q;
    assign locked   = locked_q;
    assign user_idx = uidx_q;
    assign fail_cnt = fail_q;
endmodule

// File: tb/tb_access_ctrl_gen.sv
// Directed bench for access_ctrl_gen: default build (dut_a) and a narrow build (dut_b).
// Inputs change and outputs are sampled on the falling edge.
module tb_access_ctrl_gen;
    import access_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    access_ctrl_gen_if #(.DIGIT_W(4), .NUM_USERS(8), .MAX_FAILS(3)) a ();
    access_ctrl_gen_if #(.DIGIT_W(3), .NUM_USERS(4), .MAX_FAILS(1)) b ();

    access_ctrl_gen dut_a (
        .clk(clk), .rst(rst),
        .b_ac(a.b_ac), .swt_ac(a.swt_ac), .clr(a.clr), .logout(a.logout),
        .led_r(a.led_r), .led_g(a.led_g), .locked(a.locked),
        .user_idx(a.user_idx), .fail_cnt(a.fail_cnt)
    );

    access_ctrl_gen #(
        .DIGIT_W(3), .NUM_USERS(4), .MAX_FAILS(1), .LOCK_CYCLES(20)
    ) dut_b (
        .clk(clk), .rst(rst),
        .b_ac(b.b_ac), .swt_ac(b.swt_ac), .clr(b.clr), .logout(b.logout),
        .led_r(b.led_r), .led_g(b.led_g), .locked(b.locked),
        .user_idx(b.user_idx), .fail_cnt(b.fail_cnt)
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(bit sel, logic [3:0] d);
        @(negedge clk);
        if (sel) begin
            b.b_ac = 1'b1; b.swt_ac = d[2:0];
        end else begin
            a.b_ac = 1'b1; a.swt_ac = d;
        end
        @(negedge clk);
        a.b_ac = 1'b0;
        b.b_ac = 1'b0;
    endtask

    task automatic enter(bit sel, logic [31:0] nib, int n);
        for (int i = n - 1; i >= 0; i--) press(sel, nib[4*i +: 4]);
    endtask

    task automatic login(bit sel, logic [31:0] user, logic [31:0] pass);
        enter(sel, user, 4);
        idle(12);
        enter(sel, pass, 5);
    endtask

    task automatic do_logout(bit sel);
        @(negedge clk);
        if (sel) b.logout = 1'b1; else a.logout = 1'b1;
        @(negedge clk);
        a.logout = 1'b0;
        b.logout = 1'b0;
    endtask

    task automatic wait_grant(bit sel, string tag);
        for (int k = 0; k < 10; k++) begin
            if ((sel ? b.led_g : a.led_g) == 1'b1) break;
            @(negedge clk);
        end
        check(tag, 32'(sel ? b.led_g : a.led_g), 32'd1);
    endtask

    task automatic wait_lock(bit sel);
        for (int k = 0; k < 10; k++) begin
            if ((sel ? b.locked : a.locked) == 1'b1) break;
            @(negedge clk);
        end
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_led_r"},  32'(a.led_r),    32'd1);
        check({tag, "_led_g"},  32'(a.led_g),    32'd0);
        check({tag, "_locked"}, 32'(a.locked),   32'd0);
        check({tag, "_uidx"},   32'(a.user_idx), 32'd0);
        check({tag, "_fail"},   32'(a.fail_cnt), 32'd0);
        check({tag, "_state"},  32'(dut_a.state_q), 32'(U_ENTRY));
    endtask

    initial begin
        int lk;
        a.b_ac = 1'b0; a.swt_ac = '0; a.clr = 1'b0; a.logout = 1'b0;
        b.b_ac = 1'b0; b.swt_ac = '0; b.clr = 1'b0; b.logout = 1'b0;

        idle(2);
        check_reset_outputs("rst");
        check("rst_b_led_r", 32'(b.led_r), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // valid login at index 5
        login(0, 32'h2468, 32'h13579);
        wait_grant(0, "grant5");
        check("grant5_led_r", 32'(a.led_r), 32'd0);
        check("grant5_uidx", 32'(a.user_idx), 32'd5);
        check("grant5_fail", 32'(a.fail_cnt), 32'd0);
        do_logout(0);
        idle(1);
        check("logout_led_g", 32'(a.led_g), 32'd0);
        check("logout_uidx", 32'(a.user_idx), 32'd0);

        // clr together with b_ac mid-password
        enter(0, 32'h1111, 4);
        idle(12);
        enter(0, 32'h13, 2);
        @(negedge clk);
        a.clr = 1'b1; a.b_ac = 1'b1; a.swt_ac = 4'h5;
        @(negedge clk);
        a.clr = 1'b0; a.b_ac = 1'b0;
        idle(1);
        check("clr_state", 32'(dut_a.state_q), 32'(U_ENTRY));
        check("clr_fail", 32'(a.fail_cnt), 32'd0);
        check("clr_ubuf", 32'(dut_a.ubuf_q), 32'd0);
        check("clr_pbuf", 32'(dut_a.pbuf_q), 32'd0);

        // unknown user still gets a password prompt
        enter(0, 32'h9999, 4);
        idle(12);
        check("unk_state", 32'(dut_a.state_q), 32'(P_ENTRY));
        enter(0, 32'h12345, 5);
        idle(4);
        check("unk_fail", 32'(a.fail_cnt), 32'd1);
        check("unk_led_g", 32'(a.led_g), 32'd0);
        check("unk_led_r", 32'(a.led_r), 32'd1);

        // a good login clears the failure count
        login(0, 32'h1111, 32'h11111);
        wait_grant(0, "grant0");
        check("grant0_uidx", 32'(a.user_idx), 32'd0);
        check("grant0_fail", 32'(a.fail_cnt), 32'd0);
        do_logout(0);
        idle(1);

        // three wrong passwords lock the keypad
        for (int k = 1; k <= 2; k++) begin
            login(0, 32'h2468, 32'h13570);
            idle(4);
            check("wrong_fail", 32'(a.fail_cnt), 32'(k));
            check("wrong_unlocked", 32'(a.locked), 32'd0);
        end
        login(0, 32'h2468, 32'h13570);
        wait_lock(0);
        check("lock_on", 32'(a.locked), 32'd1);
        check("lock_fail", 32'(a.fail_cnt), 32'd3);
        lk = 0;
        for (int i = 0; i < 1100 && a.locked; i++) begin
            lk++;
            if (i % 100 == 10) begin
                a.b_ac = 1'b1; a.swt_ac = 4'h7;
                a.clr = (i == 210); a.logout = (i == 310);
            end else begin
                a.b_ac = 1'b0; a.clr = 1'b0; a.logout = 1'b0;
            end
            @(negedge clk);
        end
        a.b_ac = 1'b0; a.clr = 1'b0; a.logout = 1'b0;
        check("lock_len", 32'(lk), 32'd1000);
        check("unlock_fail", 32'(a.fail_cnt), 32'd0);
        check("unlock_state", 32'(dut_a.state_q), 32'(U_ENTRY));
        check("unlock_ubuf", 32'(dut_a.ubuf_q), 32'd0);

        // reset mid-search with a pending failure
        login(0, 32'h2468, 32'h00000);
        idle(4);
        check("pre_rst_fail", 32'(a.fail_cnt), 32'd1);
        enter(0, 32'h2468, 4);
        idle(2);
        check("srch_state", 32'(dut_a.state_q), 32'(U_SEARCH));
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_srch");
        @(negedge clk);
        rst = 1'b0;
        login(0, 32'h2468, 32'h13579);
        wait_grant(0, "post_srch_grant");
        check("post_srch_uidx", 32'(a.user_idx), 32'd5);

        // reset while granted
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_grant");
        @(negedge clk);
        rst = 1'b0;
        login(0, 32'h2468, 32'h13579);
        wait_grant(0, "post_grant_grant");
        check("post_grant_uidx", 32'(a.user_idx), 32'd5);
        do_logout(0);

        // narrow build: 3-bit digits, second credential at index 3, single failure locks
        login(1, 32'h2460, 32'h13571);
        wait_grant(1, "b_grant");
        check("b_uidx", 32'(b.user_idx), 32'd3);
        check("b_fail", 32'(b.fail_cnt), 32'd0);
        do_logout(1);
        idle(1);
        check("b_logout", 32'(b.led_g), 32'd0);
        login(1, 32'h2460, 32'h13572);
        wait_lock(1);
        check("b_lock_on", 32'(b.locked), 32'd1);
        check("b_lock_fail", 32'(b.fail_cnt), 32'd1);
        lk = 0;
        for (int i = 0; i < 100 && b.locked; i++) begin
            lk++;
            @(negedge clk);
        end
        check("b_lock_len", 32'(lk), 32'd20);
        check("b_unlock_fail", 32'(b.fail_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
